scytale_encryption: RTL and testbench

//  Encrypting counterpart of scytale_decryption; sits in the encryption path feeding the demux.

---
 rtl/enc_pkg.sv | 18 +
 rtl/scytale_idx_gen.sv | 54 +++++
 rtl/scytale_encryption.sv | 137 +++++++++++++
 tb/tb_scytale_encryption.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared definitions for the encryption-path blocks (scytale, caesar, zigzag).
package enc_pkg;

  // Byte that terminates a plaintext frame and kicks off encryption.
  localparam logic [7:0] ENC_START_TOKEN = 8'hFA;

  // Default frame buffer depth in bytes.
  localparam int ENC_MAX_NOF_CHARS = 50;

  // Frame FSM: COLLECT fills the buffer, ENCRYPT streams ciphertext,
  // DRAIN is the single busy cycle spent rejecting an unusable key.
  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    ENCRYPT = 2'd1,
    DRAIN   = 2'd2
  } enc_state_e;

endpackage

// File: rtl/scytale_idx_gen.sv
// Column-major read address generator for a row-major M x N matrix.
// Walks r = 0..M-1 inside c = 0..N-1 and keeps idx = r*N + c up to date
// with adds only, so no multiplier sits in the per-byte loop.
module scytale_idx_gen #(
  parameter int KEY_WIDTH = 8
) (
  input  logic                   clk,
  input  logic [KEY_WIDTH-1:0]   n_i,
  input  logic [KEY_WIDTH-1:0]   m_i,
  input  logic                   start_i,
  input  logic                   step_i,
  output logic [2*KEY_WIDTH-1:0] idx_o,
  output logic                   last_o
);

  localparam int IDX_W = 2 * KEY_WIDTH;
  localparam logic [KEY_WIDTH-1:0] ONE = KEY_WIDTH'(1);

  logic [KEY_WIDTH-1:0] r_q, r_d;
  logic [KEY_WIDTH-1:0] c_q, c_d;
  logic [IDX_W-1:0]     idx_q, idx_d;

  // Next counter values: restart at (0,0) or advance one matrix element.
  always_comb begin
    r_d   = r_q;
    c_d   = c_q;
    idx_d = idx_q;
    if (start_i) begin
      r_d   = '0;
      c_d   = '0;
      idx_d = '0;
    end else if (step_i) begin
      if (r_q == m_i - ONE) begin
        r_d   = '0;
        c_d   = c_q + ONE;
        idx_d = IDX_W'(c_q + ONE);
      end else begin
        r_d   = r_q + ONE;
        idx_d = idx_q + IDX_W'(n_i);
      end
    end
  end

  // Counter registers; start always precedes use, so no reset is needed.
  always_ff @(posedge clk) begin
    r_q   <= r_d;
    c_q   <= c_d;
    idx_q <= idx_d;
  end

  assign idx_o  = idx_q;
  assign last_o = (r_q == m_i - ONE) && (c_q == n_i - ONE);

endmodule

// File: rtl/scytale_encryption.sv
// Scytale encryptor: buffers a plaintext frame until the start token, then
// emits the matrix column-major, one ciphertext byte per cycle.
module scytale_encryption
  import enc_pkg::*;
#(
  parameter int               D_WIDTH       = 8,
  parameter int               KEY_WIDTH     = 8,
  parameter int               MAX_NOF_CHARS = ENC_MAX_NOF_CHARS,
  parameter logic [D_WIDTH-1:0] START_TOKEN = D_WIDTH'(ENC_START_TOKEN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [D_WIDTH-1:0]   data_i,
  input  logic                 valid_i,
  input  logic [KEY_WIDTH-1:0] key_N,
  input  logic [KEY_WIDTH-1:0] key_M,
  output logic [D_WIDTH-1:0]   data_o,
  output logic                 valid_o,
  output logic                 busy
);

  localparam int PTR_W = $clog2(MAX_NOF_CHARS + 1);
  localparam int L_W   = 2 * KEY_WIDTH;

  enc_state_e           state_q;
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [KEY_WIDTH-1:0] n_q, m_q;
  logic                 fin_q;
  logic [D_WIDTH-1:0]   data_q;
  logic                 valid_q;
  logic                 busy_q;

  logic [D_WIDTH-1:0]   mem_q [MAX_NOF_CHARS];

  logic                 tok;
  logic                 byte_ok;
  logic                 room;
  logic [L_W-1:0]       l_tok;
  logic                 frame_ok;
  logic                 start_idx;
  logic                 step_idx;
  logic [L_W-1:0]       idx;
  logic                 last;
  logic [D_WIDTH-1:0]   rd_data;

  // Input qualification and key check; the product is only needed once per frame.
  always_comb begin
    tok      = valid_i && (data_i == START_TOKEN);
    byte_ok  = valid_i && (data_i != START_TOKEN);
    room     = wr_ptr_q < PTR_W'(MAX_NOF_CHARS);
    l_tok    = {{KEY_WIDTH{1'b0}}, key_N} * {{KEY_WIDTH{1'b0}}, key_M};
    frame_ok = (l_tok != '0) && (l_tok <= L_W'(MAX_NOF_CHARS));
    start_idx = (state_q == COLLECT) && tok && frame_ok;
    step_idx  = (state_q == ENCRYPT) && !fin_q;
  end

  scytale_idx_gen #(
    .KEY_WIDTH(KEY_WIDTH)
  ) u_idx_gen (
    .clk    (clk),
    .n_i    (n_q),
    .m_i    (m_q),
    .start_i(start_idx),
    .step_i (step_idx),
    .idx_o  (idx),
    .last_o (last)
  );

  // Positions past the collected bytes (short frame) read as zero padding.
  always_comb begin
    rd_data = '0;
    if (idx < L_W'(wr_ptr_q))
      rd_data = mem_q[idx[PTR_W-1:0]];
  end

  // Frame buffer write; contents survive reset, only wr_ptr is cleared.
  always_ff @(posedge clk) begin
    if (!rst && (state_q == COLLECT) && byte_ok && room)
      mem_q[wr_ptr_q] <= data_i;
  end

  // Frame FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= COLLECT;
      wr_ptr_q <= '0;
      fin_q    <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          valid_q <= 1'b0;
          if (tok) begin
            n_q     <= key_N;
            m_q     <= key_M;
            fin_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= frame_ok ? ENCRYPT : DRAIN;
          end else if (byte_ok && room) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
          end
        end
        ENCRYPT: begin
          if (fin_q) begin
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            wr_ptr_q <= '0;
            state_q  <= COLLECT;
          end else begin
            data_q  <= rd_data;
            valid_q <= 1'b1;
            fin_q   <= last;
          end
        end
        DRAIN: begin
          valid_q  <= 1'b0;
          busy_q   <= 1'b0;
          wr_ptr_q <= '0;
          state_q  <= COLLECT;
        end
        default: begin
          valid_q  <= 1'b0;
          busy_q   <= 1'b0;
          wr_ptr_q <= '0;
          state_q  <= COLLECT;
        end
      endcase
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_scytale_encryption.sv
// Self-checking bench for scytale_encryption: directed frames plus random
// frames, each compared against a column-major transposition model.
module tb_scytale_encryption;

  typedef logic [7:0] bq_t[$];

  logic       clk;
  logic       rst;
  logic [7:0] data_i;
  logic       valid_i;
  logic [7:0] key_N;
  logic [7:0] key_M;
  logic [7:0] data_o;
  logic       valid_o;
  logic       busy;

  int checks = 0;
  int errors = 0;

  scytale_encryption dut (
    .clk    (clk),
    .rst    (rst),
    .data_i (data_i),
    .valid_i(valid_i),
    .key_N  (key_N),
    .key_M  (key_M),
    .data_o (data_o),
    .valid_o(valid_o),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bq_t s2q(input string s);
    bq_t q;
    q = {};
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic bq_t rand_frame(input int len);
    bq_t q;
    logic [7:0] b;
    q = {};
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      if (b == 8'hFA) b = 8'h5A;
      q.push_back(b);
    end
    return q;
  endfunction

  // Sends one frame, then checks busy/valid_o/data_o cycle by cycle.
  // abort_at >= 0 asserts rst on the edge that would emit that output byte.
  task automatic run_frame(input bq_t pt, input int n, input int m,
                           input bit pulse, input int abort_at);
    bq_t exp;
    bq_t recv;
    int  L, eff, nbad;
    bit  ok;
    L   = n * m;
    ok  = (L > 0) && (L <= 50);
    eff = (pt.size() > 50) ? 50 : pt.size();
    exp = {};
    recv = {};
    if (ok)
      for (int c = 0; c < n; c++)
        for (int r = 0; r < m; r++)
          exp.push_back((r * n + c < eff) ? pt[r * n + c] : 8'h00);

    for (int i = 0; i < pt.size(); i++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(negedge clk);
        valid_i = 1'b0;
        data_i  = 8'hFA;
        @(posedge clk); #1;
      end
      @(negedge clk);
      valid_i = 1'b1;
      data_i  = pt[i];
      key_N   = 8'($urandom);
      key_M   = 8'($urandom);
      @(posedge clk); #1;
      chk("collect_busy", busy, 0);
      chk("collect_valid", valid_o, 0);
    end

    @(negedge clk);
    valid_i = 1'b1;
    data_i  = 8'hFA;
    key_N   = n[7:0];
    key_M   = m[7:0];
    @(posedge clk); #1;
    chk("token_busy", busy, 1);
    chk("token_valid", valid_o, 0);

    if (!ok) begin
      @(negedge clk);
      valid_i = 1'b0;
      @(posedge clk); #1;
      chk("bad_key_busy_drop", busy, 0);
      chk("bad_key_no_valid", valid_o, 0);
      return;
    end

    for (int j = 0; j < L; j++) begin
      @(negedge clk);
      if (pulse) begin
        valid_i = 1'($urandom);
        data_i  = ($urandom_range(0, 2) == 0) ? 8'hFA : 8'($urandom);
        key_N   = 8'($urandom);
        key_M   = 8'($urandom);
      end else begin
        valid_i = 1'b0;
      end
      if (j == abort_at) rst = 1'b1;
      @(posedge clk); #1;
      if (j == abort_at) begin
        chk("abort_valid", valid_o, 0);
        chk("abort_busy", busy, 0);
        chk("abort_data", data_o, 0);
        rst     = 1'b0;
        valid_i = 1'b0;
        return;
      end
      chk("enc_valid", valid_o, 1);
      chk("enc_busy", busy, 1);
      chk("enc_data", data_o, exp[j]);
      recv.push_back(data_o);
    end

    @(negedge clk);
    valid_i = 1'b0;
    @(posedge clk); #1;
    chk("end_valid", valid_o, 0);
    chk("end_busy", busy, 0);
    chk("end_data_hold", data_o, exp[L-1]);

    // Inverse transposition of the received stream must restore the plaintext.
    if (eff >= L) begin
      nbad = 0;
      for (int c = 0; c < n; c++)
        for (int r = 0; r < m; r++)
          if (recv[c * m + r] !== pt[r * n + c]) nbad++;
      chk("loopback", nbad, 0);
    end
  endtask

  initial begin
    rst     = 1'b1;
    valid_i = 1'b0;
    data_i  = 8'h00;
    key_N   = 8'd0;
    key_M   = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", data_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;

    // Basic frames, back to back with different keys.
    run_frame(s2q("ABCDEF"), 2, 3, 1'b0, -1);
    run_frame(s2q("ABCDEF"), 3, 2, 1'b0, -1);
    run_frame(s2q("WXYZ"),   1, 4, 1'b0, -1);

    // Short frame pads with zeros; unusable keys give a one-cycle busy pulse.
    run_frame(s2q("ABCD"), 2, 3, 1'b0, -1);
    run_frame(s2q("AB"),   0, 3, 1'b0, -1);
    run_frame(s2q("ABC"),  8, 8, 1'b0, -1);
    run_frame(s2q("ABCDEF"), 2, 3, 1'b0, -1);

    // Reset in the middle of emission, then a clean frame.
    run_frame(s2q("ABCDEF"), 2, 3, 1'b0, 2);
    run_frame(s2q("ABCDEF"), 2, 3, 1'b0, -1);

    // Overfull frame with input activity while busy.
    run_frame(rand_frame(55), 5, 10, 1'b1, -1);

    // Random frames, including invalid keys and short/over-length frames.
    for (int f = 0; f < 12; f++) begin
      int len, n, m;
      len = $urandom_range(0, 52);
      n   = $urandom_range(0, 9);
      m   = $urandom_range(1, 9);
      run_frame(rand_frame(len), n, m, f[0], -1);
    end

    // Full-size random frame whose key exactly fills the buffer.
    run_frame(rand_frame(50), 10, 5, 1'b1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
